// File: rtl/iir_coeff_ctrl_if.sv
// Bundle of config, sample-stream, filter-handshake and coefficient signals around
// iir_coeff_ctrl. The slave modport is the controller side; master is the surrounding system.
interface iir_coeff_ctrl_if #(
  parameter int unsigned INPUT_TAPS  = 3,
  parameter int unsigned OUTPUT_TAPS = 2,
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned COEFF_WIDTH = 18
);
  localparam int unsigned N_COEFF    = INPUT_TAPS + OUTPUT_TAPS;
  localparam int unsigned ADDR_WIDTH = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;

  logic                                   cfg_we_i;
  logic [ADDR_WIDTH-1:0]                  cfg_addr_i;
  logic [COEFF_WIDTH-1:0]                 cfg_wdata_i;
  logic                                   cfg_commit_i;
  logic                                   cfg_busy_o;
  logic                                   cfg_done_o;
  logic                                   cfg_err_o;
  logic [7:0]                             cfg_epoch_o;
  logic [DATA_WIDTH-1:0]                  s_data_i;
  logic                                   s_valid_i;
  logic                                   s_ready_o;
  logic [DATA_WIDTH-1:0]                  f_x_o;
  logic                                   f_valid_o;
  logic                                   f_ready_i;
  logic                                   f_out_valid_i;
  logic                                   f_out_ready_i;
  logic [INPUT_TAPS-1:0][COEFF_WIDTH-1:0]  coeff_x_o;
  logic [OUTPUT_TAPS-1:0][COEFF_WIDTH-1:0] coeff_y_o;

  modport slave (
    input  cfg_we_i, cfg_addr_i, cfg_wdata_i, cfg_commit_i,
    output cfg_busy_o, cfg_done_o, cfg_err_o, cfg_epoch_o,
    input  s_data_i, s_valid_i,
    output s_ready_o, f_x_o, f_valid_o,
    input  f_ready_i, f_out_valid_i, f_out_ready_i,
    output coeff_x_o, coeff_y_o
  );

  modport master (
    output cfg_we_i, cfg_addr_i, cfg_wdata_i, cfg_commit_i,
    input  cfg_busy_o, cfg_done_o, cfg_err_o, cfg_epoch_o,
    output s_data_i, s_valid_i,
    input  s_ready_o, f_x_o, f_valid_o,
    output f_ready_i, f_out_valid_i, f_out_ready_i,
    input  coeff_x_o, coeff_y_o
  );
endinterface

// File: rtl/iir_coeff_ctrl.sv
// Double-banked IIR coefficient controller: staging bank written via the config port, active
// bank swapped in atomically once accepted samples have drained out of the filter.
module iir_coeff_ctrl #(
  parameter int unsigned INPUT_TAPS   = 3,
  parameter int unsigned OUTPUT_TAPS  = 2,
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned COEFF_WIDTH  = 18,
  parameter int unsigned MAX_INFLIGHT = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  iir_coeff_ctrl_if.slave bus
);
  localparam int unsigned N_COEFF = INPUT_TAPS + OUTPUT_TAPS;
  localparam int unsigned IFW     = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {StRun, StDrain, StSwap} state_e;

  state_e                 r_state, w_state_d;
  logic                   r_pending, w_pending_d;
  logic [IFW-1:0]         r_in_flight;
  logic [7:0]             r_epoch;
  logic                   r_err;
  logic [COEFF_WIDTH-1:0] r_stage  [N_COEFF];
  logic [COEFF_WIDTH-1:0] r_active [N_COEFF];

  logic w_gate, w_accept, w_retire, w_swap, w_addr_ok;

  // rst_i is folded in so the handshake is closed while reset is held
  assign w_gate = rst_i | (r_state != StRun) | r_pending |
                  (r_in_flight == IFW'(MAX_INFLIGHT));

  assign bus.f_x_o     = bus.s_data_i;
  assign bus.f_valid_o = bus.s_valid_i & ~w_gate;
  assign bus.s_ready_o = bus.f_ready_i & ~w_gate;

  assign w_accept  = bus.s_valid_i & bus.f_ready_i & ~w_gate;
  assign w_retire  = bus.f_out_valid_i & bus.f_out_ready_i;
  assign w_swap    = (r_state == StSwap);
  assign w_addr_ok = (32'(bus.cfg_addr_i) < N_COEFF);

  assign bus.cfg_busy_o  = r_pending | (r_state != StRun);
  assign bus.cfg_done_o  = w_swap;
  assign bus.cfg_err_o   = r_err;
  assign bus.cfg_epoch_o = r_epoch;

  always_comb begin
    w_state_d   = r_state;
    w_pending_d = r_pending;
    case (r_state)
      StRun: begin
        if (bus.cfg_commit_i) begin
          w_pending_d = 1'b1;
          w_state_d   = StDrain;
        end
      end
      StDrain: begin
        if (r_in_flight == '0) w_state_d = StSwap;
      end
      StSwap: begin
        // A commit seen during the swap re-arms immediately, skipping RUN
        w_pending_d = bus.cfg_commit_i;
        w_state_d   = bus.cfg_commit_i ? StDrain : StRun;
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= StRun;
      r_pending   <= 1'b0;
      r_in_flight <= '0;
      r_epoch     <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_pending_d;
      r_err     <= bus.cfg_we_i & ~w_addr_ok;
      if (w_swap) r_epoch <= r_epoch + 8'd1;
      case ({w_accept, w_retire})
        2'b10:   r_in_flight <= r_in_flight + IFW'(1);
        2'b01:   if (r_in_flight != '0) r_in_flight <= r_in_flight - IFW'(1);
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_COEFF; i++) begin
        r_stage[i]  <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_COEFF; i++) begin
        if (bus.cfg_we_i && w_addr_ok && (32'(bus.cfg_addr_i) == i)) r_stage[i] <= bus.cfg_wdata_i;
        if (w_swap) r_active[i] <= r_stage[i];
      end
    end
  end

  always_comb begin
    bus.coeff_x_o = '0;
    bus.coeff_y_o = '0;
    for (int i = 0; i < INPUT_TAPS; i++)  bus.coeff_x_o[i] = r_active[i];
    for (int j = 0; j < OUTPUT_TAPS; j++) bus.coeff_y_o[j] = r_active[INPUT_TAPS+j];
  end
endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Directed bench for iir_coeff_ctrl: staging writes, drain-gated swaps, error pulses,
// commit merging, async reset and epoch wrap, with hand-computed expectations.
module tb_iir_coeff_ctrl;
  localparam int unsigned IT = 3, OT = 2, DW = 24, CW = 18, MI = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  iir_coeff_ctrl_if #(
    .INPUT_TAPS(IT), .OUTPUT_TAPS(OT), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)
  ) bus ();

  iir_coeff_ctrl #(
    .INPUT_TAPS(IT), .OUTPUT_TAPS(OT), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .MAX_INFLIGHT(MI)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_swap();
    logic seen;
    seen = 1'b0;
    bus.cfg_commit_i = 1'b1;
    tick();
    bus.cfg_commit_i = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      settle();
      if (bus.cfg_done_o === 1'b1) seen = 1'b1;
      tick();
    end
    chk("swap_done_seen", 32'(seen), 1);
  endtask

  initial begin
    bus.cfg_we_i      = 1'b0;
    bus.cfg_addr_i    = '0;
    bus.cfg_wdata_i   = '0;
    bus.cfg_commit_i  = 1'b0;
    bus.s_data_i      = '0;
    bus.s_valid_i     = 1'b1;
    bus.f_ready_i     = 1'b1;
    bus.f_out_valid_i = 1'b0;
    bus.f_out_ready_i = 1'b1;

    // Reset held: handshake closed even with valid/ready asserted
    #3;
    chk("rst_s_ready", 32'(bus.s_ready_o), 0);
    chk("rst_f_valid", 32'(bus.f_valid_o), 0);
    chk("rst_busy", 32'(bus.cfg_busy_o), 0);
    chk("rst_done", 32'(bus.cfg_done_o), 0);
    chk("rst_err", 32'(bus.cfg_err_o), 0);
    chk("rst_epoch", 32'(bus.cfg_epoch_o), 0);
    chk("rst_cx0", $signed(bus.coeff_x_o[0]), 0);
    bus.s_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // Staging writes do not touch the active bank; streaming is ungated
    bus.cfg_we_i    = 1'b1;
    bus.cfg_addr_i  = 3'd0;
    bus.cfg_wdata_i = 18'sd16384;
    tick();
    bus.cfg_addr_i  = 3'd4;
    bus.cfg_wdata_i = -18'sd8192;
    tick();
    bus.cfg_we_i      = 1'b0;
    bus.f_out_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = 24'h100 + 24'(i);
      settle();
      chk("stream_s_ready", 32'(bus.s_ready_o), 1);
      chk("stream_f_valid", 32'(bus.f_valid_o), 1);
      chk("stream_f_x", 32'(bus.f_x_o), 32'h100 + i);
      tick();
    end
    bus.s_valid_i     = 1'b0;
    bus.f_out_valid_i = 1'b0;
    settle();
    chk("nocommit_cx0", $signed(bus.coeff_x_o[0]), 0);
    chk("nocommit_cy1", $signed(bus.coeff_y_o[1]), 0);
    chk("nocommit_busy", 32'(bus.cfg_busy_o), 0);
    tick();

    // Commit with one sample in flight
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = 24'hABCDE;
    settle();
    chk("t3_accept", 32'(bus.s_ready_o), 1);
    tick();
    bus.cfg_commit_i = 1'b1;
    settle();
    chk("t3_full_gate", 32'(bus.s_ready_o), 0);
    tick();
    bus.cfg_commit_i = 1'b0;
    settle();
    chk("t3_busy", 32'(bus.cfg_busy_o), 1);
    chk("t3_drain_ready", 32'(bus.s_ready_o), 0);
    chk("t3_drain_valid", 32'(bus.f_valid_o), 0);
    tick();
    bus.f_out_valid_i = 1'b1;
    settle();
    chk("t3_drain_done", 32'(bus.cfg_done_o), 0);
    tick();
    bus.f_out_valid_i = 1'b0;
    settle();
    chk("t3_empty_ready", 32'(bus.s_ready_o), 0);
    chk("t3_empty_done", 32'(bus.cfg_done_o), 0);
    tick();
    settle();
    chk("t3_swap_done", 32'(bus.cfg_done_o), 1);
    chk("t3_swap_busy", 32'(bus.cfg_busy_o), 1);
    chk("t3_swap_old_cx0", $signed(bus.coeff_x_o[0]), 0);
    tick();
    settle();
    chk("t3_done_off", 32'(bus.cfg_done_o), 0);
    chk("t3_busy_off", 32'(bus.cfg_busy_o), 0);
    chk("t3_epoch", 32'(bus.cfg_epoch_o), 1);
    chk("t3_cx0", $signed(bus.coeff_x_o[0]), 16384);
    chk("t3_cy1", $signed(bus.coeff_y_o[1]), -8192);
    chk("t3_resume", 32'(bus.s_ready_o), 1);
    tick();
    bus.s_valid_i     = 1'b0;
    bus.f_out_valid_i = 1'b1;
    tick();
    bus.f_out_valid_i = 1'b0;

    // Out-of-range write
    bus.cfg_we_i    = 1'b1;
    bus.cfg_addr_i  = 3'd5;
    bus.cfg_wdata_i = 18'sd123;
    settle();
    chk("t4_err_pre", 32'(bus.cfg_err_o), 0);
    tick();
    bus.cfg_we_i = 1'b0;
    settle();
    chk("t4_err", 32'(bus.cfg_err_o), 1);
    chk("t4_cx0_kept", $signed(bus.coeff_x_o[0]), 16384);
    tick();
    settle();
    chk("t4_err_off", 32'(bus.cfg_err_o), 0);

    // Write landing in the SWAP cycle only reaches staging
    bus.cfg_commit_i = 1'b1;
    tick();
    bus.cfg_commit_i = 1'b0;
    settle();
    chk("t5_busy", 32'(bus.cfg_busy_o), 1);
    tick();
    bus.cfg_we_i    = 1'b1;
    bus.cfg_addr_i  = 3'd2;
    bus.cfg_wdata_i = 18'sd777;
    settle();
    chk("t5_swap_done", 32'(bus.cfg_done_o), 1);
    tick();
    bus.cfg_we_i = 1'b0;
    settle();
    chk("t5_cx2_old", $signed(bus.coeff_x_o[2]), 0);
    chk("t5_epoch2", 32'(bus.cfg_epoch_o), 2);
    bus.cfg_commit_i = 1'b1;
    tick();
    bus.cfg_commit_i = 1'b0;
    tick();
    settle();
    chk("t5_swap2_done", 32'(bus.cfg_done_o), 1);
    tick();
    settle();
    chk("t5_cx2_new", $signed(bus.coeff_x_o[2]), 777);
    chk("t5_cx0", $signed(bus.coeff_x_o[0]), 16384);
    chk("t5_cy0", $signed(bus.coeff_y_o[0]), 0);
    chk("t5_epoch3", 32'(bus.cfg_epoch_o), 3);

    // Asynchronous reset mid-cycle clears everything immediately
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cx0", $signed(bus.coeff_x_o[0]), 0);
    chk("arst_cx2", $signed(bus.coeff_x_o[2]), 0);
    chk("arst_cy1", $signed(bus.coeff_y_o[1]), 0);
    chk("arst_epoch", 32'(bus.cfg_epoch_o), 0);
    chk("arst_s_ready", 32'(bus.s_ready_o), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Commits in DRAIN merge; commit in SWAP re-arms exactly one more swap
    bus.s_valid_i = 1'b1;
    tick();
    bus.s_valid_i    = 1'b0;
    bus.cfg_commit_i = 1'b1;
    tick();
    settle();
    chk("t6_busy", 32'(bus.cfg_busy_o), 1);
    tick();
    settle();
    chk("t6_hold_done", 32'(bus.cfg_done_o), 0);
    tick();
    bus.cfg_commit_i  = 1'b0;
    bus.f_out_valid_i = 1'b1;
    tick();
    bus.f_out_valid_i = 1'b0;
    settle();
    chk("t6_pre_swap", 32'(bus.cfg_done_o), 0);
    tick();
    bus.cfg_commit_i = 1'b1;
    settle();
    chk("t6_swap1", 32'(bus.cfg_done_o), 1);
    tick();
    bus.cfg_commit_i = 1'b0;
    settle();
    chk("t6_rearm_done", 32'(bus.cfg_done_o), 0);
    chk("t6_rearm_busy", 32'(bus.cfg_busy_o), 1);
    chk("t6_epoch1", 32'(bus.cfg_epoch_o), 1);
    tick();
    settle();
    chk("t6_swap2", 32'(bus.cfg_done_o), 1);
    tick();
    settle();
    chk("t6_idle_done", 32'(bus.cfg_done_o), 0);
    chk("t6_idle_busy", 32'(bus.cfg_busy_o), 0);
    chk("t6_epoch2", 32'(bus.cfg_epoch_o), 2);
    tick();
    settle();
    chk("t6_no_extra", 32'(bus.cfg_epoch_o), 2);

    // Epoch wrap
    for (int i = 0; i < 253; i++) do_swap();
    settle();
    chk("wrap_255", 32'(bus.cfg_epoch_o), 255);
    do_swap();
    settle();
    chk("wrap_0", 32'(bus.cfg_epoch_o), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
